rsa_arbiter: RTL and testbench

Round-robin scheduler that shares one `RSA` modular-exponentiation core (Result = Data^Key mod N) among `NREQ` requesters. It captures the winning requester's operands and starts the core by pulsing its reset. It then waits for `Done` and returns the result with a one-cycle valid strobe addressed to the owner. It sits between the requester-side logic and the single `RSA` instance.

---
 rtl/rsa_arbiter.sv | 143 ++++++++++++++
 tb/tb_rsa_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_arbiter.sv
// rsa_arbiter: round-robin scheduler sharing one RSA modexp core among NREQ requesters.
// Optional RUN watchdog is compiled in when RSA_ARB_TIMEOUT_EN is defined.
module rsa_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned W          = 6,
  parameter int unsigned TMO_CYCLES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data_in,
  input  logic [NREQ*W-1:0] key_in,
  input  logic [NREQ*W-1:0] n_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_err,
  output logic              busy,
  output logic              core_reset,
  output logic [W-1:0]      core_data,
  output logic [W-1:0]      core_key,
  output logic [W-1:0]      core_n,
  input  logic [W-1:0]      core_result,
  input  logic              core_done
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  if (NREQ < 2 || NREQ > 8 || TMO_CYCLES < 1) begin : g_param_chk
    $error("rsa_arbiter: parameter out of range");
  end

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_owner_oh;
  logic            r_first;
  logic [PW-1:0]   w_pick;
  logic            w_pick_vld;
  logic [NREQ-1:0] w_pick_oh;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TMO_CYCLES + 1) > 8) ? $clog2(TMO_CYCLES + 1) : 8;
  logic [CW-1:0] r_cnt;
  logic          w_tmo;
  assign w_tmo = (r_cnt == CW'(TMO_CYCLES - 1));
`else
  assign rsp_err = 1'b0;
`endif

  // First requester at or after ptr+1, wrapping modulo NREQ.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_ptr;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!w_pick_vld && req[PW'((32'(r_ptr) + k) % NREQ)]) begin
        w_pick_vld = 1'b1;
        w_pick     = PW'((32'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= PW'(NREQ - 1);
      r_owner_oh <= '0;
      r_first    <= 1'b0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
      core_reset <= 1'b1;
      core_data  <= '0;
      core_key   <= '0;
      core_n     <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      r_cnt      <= '0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            core_data  <= data_in[32'(w_pick) * W +: W];
            core_key   <= key_in[32'(w_pick) * W +: W];
            core_n     <= n_in[32'(w_pick) * W +: W];
            r_ptr      <= w_pick;
            r_owner_oh <= w_pick_oh;
            gnt        <= w_pick_oh;
            busy       <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          core_reset <= 1'b0;
          r_first    <= 1'b1;
          r_state    <= S_RUN;
`ifdef RSA_ARB_TIMEOUT_EN
          r_cnt      <= '0;
`endif
        end
        S_RUN: begin
          // Done may be stale on the first cycle out of core reset.
          r_first <= 1'b0;
          if (!r_first && core_done) begin
            rsp_result <= core_result;
            rsp_valid  <= r_owner_oh;
            core_reset <= 1'b1;
            r_state    <= S_RESP;
`ifdef RSA_ARB_TIMEOUT_EN
            rsp_err    <= 1'b0;
          end else if (w_tmo) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= r_owner_oh;
            core_reset <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
`endif
          end
        end
        S_RESP: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_arbiter.sv
// tb_rsa_arbiter: directed and randomized checks of rsa_arbiter against a job-schedule model
// with a behavioural RSA core stub.
`timescale 1ns/1ps
module tb_rsa_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 6;
  localparam int TMO  = 16;
`ifdef RSA_ARB_TIMEOUT_EN
  localparam int TMO_LIM = TMO;
`else
  localparam int TMO_LIM = 1 << 30;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] data_in = '0;
  logic [NREQ*W-1:0] key_in = '0;
  logic [NREQ*W-1:0] n_in = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [W-1:0]      rsp_result, core_data, core_key, core_n;
  logic [W-1:0]      core_result = '0;
  logic              rsp_err, busy, core_reset;
  logic              core_done = 1'b0;

  always #5 clk = ~clk;

  rsa_arbiter #(.NREQ(NREQ), .W(W), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .key_in(key_in), .n_in(n_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .core_reset(core_reset), .core_data(core_data), .core_key(core_key),
    .core_n(core_n), .core_result(core_result), .core_done(core_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Requesters
  bit pend [NREQ];
  int rd [NREQ];
  int rk [NREQ];
  int rn [NREQ];

  // Model: the current job as a schedule of edge numbers
  int m_ptr = NREQ - 1;
  bit m_valid = 1'b0;
  int m_k, m_resp, m_owner, m_res;
  bit m_err;
  int m_next = 0;
  int m_last_res = 0;
  bit m_last_err = 1'b0;
  int m_cd = 0, m_ck = 0, m_cn = 0;

  // Core stub and observations
  int s_cnt = 0;
  bit s_prev_cr = 1'b1;
  int job_lat = 1;
  int lat_override = -1;
  int gq [$];
  int rq [$];
  int rsp_seen = 0;
  int last_rsp = 0;
  bit last_err = 1'b0;
  int last_gnt_cyc = 0;
  int last_rsp_cyc = 0;

  function automatic int modexp(int d, int k, int n);
    int r;
    if (n == 0) return 0;
    r = 1 % n;
    for (int i = 0; i < k; i++) r = (r * d) % n;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    int e;
    int exp_gnt, exp_rv;
    bit exp_busy, exp_cr;
    @(negedge clk);
    e = cyc + 1;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = pend[i];
      data_in[i*W +: W] = W'(rd[i]);
      key_in[i*W +: W]  = W'(rk[i]);
      n_in[i*W +: W]    = W'(rn[i]);
    end
    s_prev_cr = core_reset;
    if (core_reset) begin
      core_done   = 1'($urandom_range(1, 0));
      core_result = W'($urandom);
    end else if (s_cnt == 0) begin
      core_done   = 1'($urandom_range(1, 0));
      core_result = W'($urandom);
    end else if (s_cnt >= job_lat) begin
      core_done   = 1'b1;
      core_result = W'(modexp(int'(core_data), int'(core_key), int'(core_n)));
    end else begin
      core_done   = 1'b0;
      core_result = W'($urandom);
    end
    if (e >= m_next) begin
      int pick = -1;
      for (int off = 1; off <= NREQ; off++) begin
        int j = (m_ptr + off) % NREQ;
        if (pick < 0 && pend[j]) pick = j;
      end
      if (pick >= 0) begin
        int run_len;
        m_owner = pick;
        m_ptr   = pick;
        m_k     = e;
        m_valid = 1'b1;
        job_lat = (lat_override >= 0) ? lat_override : int'($urandom_range(20, 1));
        run_len = (job_lat + 1 < TMO_LIM) ? job_lat + 1 : TMO_LIM;
        m_resp  = e + 1 + run_len;
        m_err   = (job_lat + 1 > TMO_LIM);
        m_res   = m_err ? 0 : modexp(rd[pick], rk[pick], rn[pick]);
        m_next  = m_resp + 2;
        m_cd = rd[pick]; m_ck = rk[pick]; m_cn = rn[pick];
      end
    end
    @(posedge clk);
    #1;
    if (m_valid && e == m_resp) begin
      m_last_res = m_res;
      m_last_err = m_err;
    end
    exp_gnt  = (m_valid && e == m_k) ? (1 << m_owner) : 0;
    exp_rv   = (m_valid && e == m_resp) ? (1 << m_owner) : 0;
    exp_busy = m_valid && e >= m_k && e <= m_resp;
    exp_cr   = !(m_valid && e >= m_k + 1 && e <= m_resp - 1);
    chk("gnt", int'(gnt), exp_gnt);
    chk("rsp_valid", int'(rsp_valid), exp_rv);
    chk("rsp_result", int'(rsp_result), m_last_res);
    chk("rsp_err", int'(rsp_err), int'(m_last_err));
    chk("busy", int'(busy), int'(exp_busy));
    chk("core_reset", int'(core_reset), int'(exp_cr));
    chk("core_data", int'(core_data), m_cd);
    chk("core_key", int'(core_key), m_ck);
    chk("core_n", int'(core_n), m_cn);
    s_cnt = s_prev_cr ? 0 : s_cnt + 1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gq.push_back(i);
        pend[i] = 1'b0;
        last_gnt_cyc = cyc;
      end
    end
    if (rsp_valid != '0) begin
      rsp_seen++;
      last_rsp = int'(rsp_result);
      last_err = rsp_err;
      last_rsp_cyc = cyc;
      rq.push_back(int'(rsp_result));
    end
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while (n < maxc && (any_pend() || (m_valid && cyc <= m_resp + 1))) begin
      step();
      n++;
    end
    chk("drain_bound", int'(n < maxc), 1);
  endtask

  task automatic do_reset(int hold);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_result", int'(rsp_result), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_core_reset", int'(core_reset), 1);
    chk("rst_core_ops", int'({core_data, core_key, core_n}), 0);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    req = '0;
    m_valid = 1'b0; m_ptr = NREQ - 1; m_next = 0;
    m_last_res = 0; m_last_err = 1'b0;
    m_cd = 0; m_ck = 0; m_cn = 0;
    s_cnt = 0; lat_override = -1;
    repeat (hold) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_req(int i, int d, int k, int n);
    rd[i] = d; rk[i] = k; rn[i] = n; pend[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; rd[i] = 0; rk[i] = 0; rn[i] = 1;
    end
    chk("model_4_3_33", modexp(4, 3, 33), 31);
    chk("model_2_5_21", modexp(2, 5, 21), 11);
    chk("model_28_60_28", modexp(28, 60, 28), 0);
    do_reset(2);

    // Single request, then minimum latency
    gq.delete(); rsp_seen = 0;
    set_req(0, 4, 3, 33); lat_override = 7;
    drain(100);
    chk("t1_gnt_who", (gq.size() == 1) ? gq[0] : -1, 0);
    chk("t1_rsp_count", rsp_seen, 1);
    chk("t1_result", last_rsp, 31);
    chk("t1_err", int'(last_err), 0);
    set_req(2, 4, 3, 33); lat_override = 1;
    drain(100);
    chk("t1_min_latency", last_rsp_cyc - last_gnt_cyc, 3);

    // Round-robin from reset: 0,1,2,3 each 2^5 mod 21
    do_reset(2);
    gq.delete(); rq.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 2, 5, 21);
    drain(400);
    for (int i = 0; i < NREQ; i++) begin
      chk("t2_order", (gq.size() > i) ? gq[i] : -1, i);
      chk("t2_result", (rq.size() > i) ? rq[i] : -1, 11);
    end

    // Fairness after wrap
    gq.delete();
    set_req(1, 5, 7, 13); set_req(3, 9, 2, 50);
    drain(200);
    chk("t3_first", (gq.size() > 0) ? gq[0] : -1, 1);
    chk("t3_second", (gq.size() > 1) ? gq[1] : -1, 3);

    // Mid-operation reset, then a fresh request
    do_reset(2);
    rsp_seen = 0; gq.delete();
    set_req(0, 3, 7, 40); lat_override = 1000;
    for (int n = 0; n < 50 && !(m_valid && cyc >= m_k + 5); n++) step();
    chk("t4_in_run", int'(busy && !core_reset), 1);
    do_reset(3);
    chk("t4_no_rsp", rsp_seen, 0);
    set_req(2, 28, 60, 28); lat_override = 10;
    drain(100);
    chk("t4_gnt_who", (gq.size() > 0) ? gq[gq.size()-1] : -1, 2);
    chk("t4_rsp_count", rsp_seen, 1);
    chk("t4_result", last_rsp, 0);

    // Stuck core: watchdog response, or no response at all
    rsp_seen = 0;
    set_req(1, 7, 9, 31); lat_override = 1000;
    repeat (40) step();
`ifdef RSA_ARB_TIMEOUT_EN
    chk("t5_rsp_count", rsp_seen, 1);
    chk("t5_err", int'(last_err), 1);
    chk("t5_result", last_rsp, 0);
`else
    chk("t5_no_rsp", rsp_seen, 0);
`endif
    do_reset(2);

    // Done on the watchdog cycle
    rsp_seen = 0;
    set_req(3, 4, 3, 33); lat_override = TMO - 1;
    drain(100);
    chk("t6_rsp_count", rsp_seen, 1);
    chk("t6_err", int'(last_err), 0);
    chk("t6_result", last_rsp, 31);

    // Random traffic
    lat_override = -1;
    repeat (600) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(3, 0) == 0)
          set_req(i, int'($urandom_range(63, 0)), int'($urandom_range(63, 0)),
                  int'($urandom_range(63, 1)));
      end
      step();
    end
    drain(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
